uni2axi_bridge: RTL and testbench

- Slave/responder end of the uni_if load/store request interface.
- Accepts one request at a time from the LSU-side master (valid held until ready; reqtyp 1 = write).
- Converts each request into a single-beat AXI4 read or write transaction on a 64-bit bus.
- Returns ready as a one-cycle pulse with lane-aligned rdata. Sits between the LSU and the memory/peripheral crossbar.

---
 rtl/uni2axi_bridge_pkg.sv | 34 +++
 rtl/uni_if.sv | 15 +
 rtl/uni2axi_bridge_lane_align.sv | 37 +++
 rtl/uni2axi_bridge.sv | 252 +++++++++++++++++++++++++
 tb/tb_uni2axi_bridge.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uni2axi_bridge_pkg.sv
// Shared types and constants for the uni_if to AXI4 bridge.
package uni2axi_bridge_pkg;

    localparam int unsigned AXI_ADDR_W = 64;
    localparam int unsigned AXI_DATA_W = 64;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
    localparam int unsigned CNT_W      = 32;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } uni_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RDATA,
        ST_WREQ,
        ST_WRESP,
        ST_DONE
    } bridge_state_e;

endpackage

// File: rtl/uni_if.sv
// LSU load/store request interface: master holds valid until a one-cycle ready.
interface uni_if;
    logic        valid;
    logic        reqtyp;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic        ready;
    logic [63:0] rdata;

    modport Master (output valid, output reqtyp, output addr, output wdata, output size,
                    input ready, input rdata);
    modport Slave  (input valid, input reqtyp, input addr, input wdata, input size,
                    output ready, output rdata);
endinterface

// File: rtl/uni2axi_bridge_lane_align.sv
// Byte-lane alignment between uni_if scalar data and the 64-bit AXI data bus.
module uni_lane_align
    import uni2axi_bridge_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [2:0]  i_addr_lo,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_axi_rdata,
    output logic [7:0]  o_wstrb_c,
    output logic [63:0] o_wdata_c,
    output logic [63:0] o_rdata_c,
    output logic        o_misalign_c
);

    logic [7:0] mask;
    logic [5:0] shamt;

    assign shamt = {i_addr_lo, 3'b000};

    // Size-dependent byte mask and natural-alignment check.
    always_comb begin
        mask         = 8'h00;
        o_misalign_c = 1'b0;
        case (uni_size_e'(i_size))
            SZ_BYTE:  mask = 8'h01;
            SZ_HALF:  begin mask = 8'h03; o_misalign_c = i_addr_lo[0];     end
            SZ_WORD:  begin mask = 8'h0F; o_misalign_c = |i_addr_lo[1:0];  end
            SZ_DWORD: begin mask = 8'hFF; o_misalign_c = |i_addr_lo;       end
            default:  mask = 8'h00;
        endcase
    end

    assign o_wstrb_c = 8'(mask << i_addr_lo);
    assign o_wdata_c = i_wdata << shamt;
    assign o_rdata_c = i_axi_rdata >> shamt;

endmodule

// File: rtl/uni2axi_bridge.sv
// Responder for uni_if requests, issuing one single-beat AXI4 transaction each.
module uni2axi_bridge
    import uni2axi_bridge_pkg::*;
#(
    parameter int unsigned AXI_ID_W = 4,
    parameter int unsigned AXI_ID   = 0,
    parameter int unsigned TIMEOUT  = 0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    uni_if.Slave                UniIf_S,
    output logic                o_axi_awvalid,
    input  logic                i_axi_awready,
    output logic [63:0]         o_axi_awaddr,
    output logic [AXI_ID_W-1:0] o_axi_awid,
    output logic [7:0]          o_axi_awlen,
    output logic [2:0]          o_axi_awsize,
    output logic [1:0]          o_axi_awburst,
    output logic                o_axi_wvalid,
    input  logic                i_axi_wready,
    output logic [63:0]         o_axi_wdata,
    output logic [7:0]          o_axi_wstrb,
    output logic                o_axi_wlast,
    input  logic                i_axi_bvalid,
    output logic                o_axi_bready,
    input  logic [1:0]          i_axi_bresp,
    output logic                o_axi_arvalid,
    input  logic                i_axi_arready,
    output logic [63:0]         o_axi_araddr,
    output logic [AXI_ID_W-1:0] o_axi_arid,
    output logic [7:0]          o_axi_arlen,
    output logic [2:0]          o_axi_arsize,
    output logic [1:0]          o_axi_arburst,
    input  logic                i_axi_rvalid,
    output logic                o_axi_rready,
    input  logic [63:0]         i_axi_rdata,
    input  logic [1:0]          i_axi_rresp,
    input  logic                i_axi_rlast,
    output logic                o_bus_err
);

    bridge_state_e    state_q, state_d;
    logic [63:0]      addr_q, addr_d;
    logic [1:0]       size_q, size_d;
    logic [63:0]      wdata_q, wdata_d;
    logic [7:0]       wstrb_q, wstrb_d;
    logic [63:0]      rdata_q, rdata_d;
    logic             awvalid_q, awvalid_d;
    logic             wvalid_q, wvalid_d;
    logic             bready_q, bready_d;
    logic             arvalid_q, arvalid_d;
    logic             rready_q, rready_d;
    logic             ready_q, ready_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]  la_size;
    logic [2:0]  la_addr_lo;
    logic [7:0]  la_wstrb_c;
    logic [63:0] la_wdata_c;
    logic [63:0] la_rdata_c;
    logic        la_misalign_c;
    logic        timeout_hit_c;
    logic        aw_hs_c, w_hs_c;
    logic        unused_ok;

    // Read data only needs the error bit of the response; rlast is ignored.
    assign unused_ok = &{1'b0, i_axi_rlast, i_axi_rresp[0], i_axi_bresp[0]};

    // Alignment uses the live request in IDLE and the latched one afterwards.
    assign la_size    = (state_q == ST_IDLE) ? UniIf_S.size       : size_q;
    assign la_addr_lo = (state_q == ST_IDLE) ? UniIf_S.addr[2:0]  : addr_q[2:0];

    uni_lane_align u_lane_align (
        .i_size       (la_size),
        .i_addr_lo    (la_addr_lo),
        .i_wdata      (UniIf_S.wdata),
        .i_axi_rdata  (i_axi_rdata),
        .o_wstrb_c    (la_wstrb_c),
        .o_wdata_c    (la_wdata_c),
        .o_rdata_c    (la_rdata_c),
        .o_misalign_c (la_misalign_c)
    );

    assign timeout_hit_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign aw_hs_c       = awvalid_q && i_axi_awready;
    assign w_hs_c        = wvalid_q && i_axi_wready;

    // Next-state and next-output logic; every handshake output is registered.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        ready_d   = 1'b0;
        bus_err_d = 1'b0;
        cnt_d     = cnt_q + CNT_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (UniIf_S.valid) begin
                    addr_d  = UniIf_S.addr;
                    size_d  = UniIf_S.size;
                    wdata_d = la_wdata_c;
                    wstrb_d = la_wstrb_c;
                    rdata_d = '0;
                    if (la_misalign_c) begin
                        state_d   = ST_DONE;
                        ready_d   = 1'b1;
                        bus_err_d = 1'b1;
                    end else if (UniIf_S.reqtyp) begin
                        state_d   = ST_WREQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_RADDR: begin
                if (i_axi_arready) begin
                    state_d   = ST_RDATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    cnt_d     = '0;
                end else if (timeout_hit_c) begin
                    state_d   = ST_DONE;
                    arvalid_d = 1'b0;
                    ready_d   = 1'b1;
                    bus_err_d = 1'b1;
                end
            end
            ST_RDATA: begin
                if (i_axi_rvalid) begin
                    state_d   = ST_DONE;
                    rready_d  = 1'b0;
                    ready_d   = 1'b1;
                    bus_err_d = i_axi_rresp[1];
                    rdata_d   = i_axi_rresp[1] ? 64'd0 : la_rdata_c;
                end else if (timeout_hit_c) begin
                    state_d   = ST_DONE;
                    rready_d  = 1'b0;
                    ready_d   = 1'b1;
                    bus_err_d = 1'b1;
                end
            end
            ST_WREQ: begin
                if (aw_hs_c) awvalid_d = 1'b0;
                if (w_hs_c)  wvalid_d  = 1'b0;
                if ((!awvalid_q || aw_hs_c) && (!wvalid_q || w_hs_c)) begin
                    state_d  = ST_WRESP;
                    bready_d = 1'b1;
                    cnt_d    = '0;
                end else if (timeout_hit_c) begin
                    state_d   = ST_DONE;
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    ready_d   = 1'b1;
                    bus_err_d = 1'b1;
                end
            end
            ST_WRESP: begin
                if (i_axi_bvalid) begin
                    state_d   = ST_DONE;
                    bready_d  = 1'b0;
                    ready_d   = 1'b1;
                    bus_err_d = i_axi_bresp[1];
                end else if (timeout_hit_c) begin
                    state_d   = ST_DONE;
                    bready_d  = 1'b0;
                    ready_d   = 1'b1;
                    bus_err_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ready_q   <= 1'b0;
            bus_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ready_q   <= ready_d;
            bus_err_q <= bus_err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign UniIf_S.ready = ready_q;
    assign UniIf_S.rdata = rdata_q;
    assign o_bus_err     = bus_err_q;

    assign o_axi_awvalid = awvalid_q;
    assign o_axi_awaddr  = addr_q;
    assign o_axi_awid    = AXI_ID_W'(AXI_ID);
    assign o_axi_awlen   = 8'd0;
    assign o_axi_awsize  = {1'b0, size_q};
    assign o_axi_awburst = AXI_BURST_INCR;
    assign o_axi_wvalid  = wvalid_q;
    assign o_axi_wdata   = wdata_q;
    assign o_axi_wstrb   = wstrb_q;
    assign o_axi_wlast   = 1'b1;
    assign o_axi_bready  = bready_q;

    assign o_axi_arvalid = arvalid_q;
    assign o_axi_araddr  = addr_q;
    assign o_axi_arid    = AXI_ID_W'(AXI_ID);
    assign o_axi_arlen   = 8'd0;
    assign o_axi_arsize  = {1'b0, size_q};
    assign o_axi_arburst = AXI_BURST_INCR;
    assign o_axi_rready  = rready_q;

endmodule

// File: tb/tb_uni2axi_bridge.sv
// Scoreboard bench for uni2axi_bridge with a small reactive AXI slave.
module tb_uni2axi_bridge;

    logic clk;
    logic rst_n;

    uni_if u_if ();

    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast, bus_err;
    logic [63:0] awaddr, wdata, araddr, rdata_ax;
    logic [3:0]  awid, arid;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;

    uni2axi_bridge #(.AXI_ID_W(4), .AXI_ID(5), .TIMEOUT(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .UniIf_S(u_if),
        .o_axi_awvalid(awvalid), .i_axi_awready(awready), .o_axi_awaddr(awaddr),
        .o_axi_awid(awid), .o_axi_awlen(awlen), .o_axi_awsize(awsize), .o_axi_awburst(awburst),
        .o_axi_wvalid(wvalid), .i_axi_wready(wready), .o_axi_wdata(wdata),
        .o_axi_wstrb(wstrb), .o_axi_wlast(wlast),
        .i_axi_bvalid(bvalid), .o_axi_bready(bready), .i_axi_bresp(bresp),
        .o_axi_arvalid(arvalid), .i_axi_arready(arready), .o_axi_araddr(araddr),
        .o_axi_arid(arid), .o_axi_arlen(arlen), .o_axi_arsize(arsize), .o_axi_arburst(arburst),
        .i_axi_rvalid(rvalid), .o_axi_rready(rready), .i_axi_rdata(rdata_ax),
        .i_axi_rresp(rresp), .i_axi_rlast(rlast), .o_bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- AXI slave model ----------------
    logic        silent = 1'b0;
    logic        r_hold = 1'b0;
    int          aw_wait = 0;
    int          w_wait  = 0;
    logic [63:0] slv_rdata = '0;
    logic [1:0]  slv_rresp = 2'b00;
    logic [1:0]  slv_bresp = 2'b00;
    int          aw_cnt, w_cnt;
    logic        r_pend, b_pend, aw_got, w_got;

    assign awready  = !silent && awvalid && (aw_cnt >= aw_wait);
    assign wready   = !silent && wvalid && (w_cnt >= w_wait);
    assign arready  = !silent && arvalid;
    assign rvalid   = r_pend && !r_hold;
    assign rdata_ax = slv_rdata;
    assign rresp    = slv_rresp;
    assign rlast    = 1'b1;
    assign bvalid   = b_pend;
    assign bresp    = slv_bresp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0;
            r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            logic aw_n, w_n;
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            if (arvalid && arready)    r_pend <= 1'b1;
            else if (rvalid && rready) r_pend <= 1'b0;
            aw_n = aw_got || (awvalid && awready);
            w_n  = w_got || (wvalid && wready);
            if (aw_n && w_n) begin
                b_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                aw_got <= aw_n; w_got <= w_n;
                if (bvalid && bready) b_pend <= 1'b0;
            end
        end
    end

    // ---------------- AXI channel checks and activity counters ----------------
    logic [63:0] exp_addr;
    logic [2:0]  exp_size;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_wstrb;
    int ar_cyc = 0, aw_cyc = 0, w_cyc = 0, overlap = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            ar_cyc  = ar_cyc + int'(arvalid);
            aw_cyc  = aw_cyc + int'(awvalid);
            w_cyc   = w_cyc + int'(wvalid);
            overlap = overlap + int'(bready && (awvalid || wvalid));
            if (arvalid && arready) begin
                chk("araddr", araddr, exp_addr);
                chk("arsize", 64'(arsize), 64'(exp_size));
                chk("arlen_burst_id", {44'd0, arlen, arburst, arid}, {44'd0, 8'd0, 2'b01, 4'h5});
            end
            if (awvalid && awready) begin
                chk("awaddr", awaddr, exp_addr);
                chk("awsize", 64'(awsize), 64'(exp_size));
                chk("awlen_burst_id", {44'd0, awlen, awburst, awid}, {44'd0, 8'd0, 2'b01, 4'h5});
            end
            if (wvalid && wready) begin
                chk("wdata", wdata, exp_wdata);
                chk("wstrb_wlast", {55'd0, wstrb, wlast}, {55'd0, exp_wstrb, 1'b1});
            end
        end
    end

    // ---------------- Scoreboard ----------------
    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   issue_cyc = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (u_if.ready) begin
                if (sb_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_ready: got ready=1 expected no response (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("rdata", u_if.rdata, e.rdata);
                    chk("bus_err", 64'(bus_err), 64'(e.err));
                    if (e.lat >= 0) chk("latency", 64'(cyc - issue_cyc), 64'(e.lat));
                end
            end else if (bus_err) begin
                n_vec++; n_err++;
                $display("FAIL err_without_ready: got bus_err=1 expected 0 (cycle %0d)", cyc);
            end
        end
    end

    // ---------------- Stimulus ----------------
    task automatic do_req(input logic typ, input logic [63:0] addr, input logic [63:0] wd,
                          input logic [1:0] sz, input logic [63:0] er, input logic ee, input int lat);
        exp_t e;
        bit   got;
        e.rdata = er; e.err = ee; e.lat = lat;
        sb_q.push_back(e);
        exp_addr = addr; exp_size = {1'b0, sz};
        ar_cyc = 0; aw_cyc = 0; w_cyc = 0; overlap = 0;
        u_if.valid = 1'b1; u_if.reqtyp = typ; u_if.addr = addr; u_if.wdata = wd; u_if.size = sz;
        issue_cyc = cyc;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (u_if.ready) begin got = 1'b1; break; end
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL ready_timeout: got no ready within 60 cycles expected ready (addr 0x%0h)", addr);
            void'(sb_q.pop_front());
        end
        u_if.valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        u_if.valid = 1'b0; u_if.reqtyp = 1'b0; u_if.addr = '0; u_if.wdata = '0; u_if.size = '0;
        exp_addr = '0; exp_size = '0; exp_wdata = '0; exp_wstrb = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ready_rdata", {63'd0, u_if.ready} | u_if.rdata, 64'd0);
        chk("rst_valids", {58'd0, awvalid, wvalid, bready, arvalid, rready, bus_err}, 64'd0);
        chk("rst_addr_data", awaddr | wdata | 64'(wstrb), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // LD 0x8000_0008
        slv_rdata = 64'h1122334455667788;
        do_req(1'b0, 64'h8000_0008, 64'd0, 2'b11, 64'h1122334455667788, 1'b0, 3);
        chk("ld_ar_cycles", 64'(ar_cyc), 64'd1);

        // SB 0x8000_0003
        exp_wdata = 64'h00000000AB000000; exp_wstrb = 8'h08;
        do_req(1'b1, 64'h8000_0003, 64'hAB, 2'b00, 64'd0, 1'b0, 3);

        // LH 0x8000_0006
        slv_rdata = 64'hBEEF_0000_0000_0000;
        do_req(1'b0, 64'h8000_0006, 64'd0, 2'b01, 64'h000000000000BEEF, 1'b0, 3);

        // SW with awready delayed 3 cycles
        aw_wait = 3;
        exp_wdata = 64'h00000000DEADBEEF; exp_wstrb = 8'h0F;
        do_req(1'b1, 64'h8000_0010, 64'hDEADBEEF, 2'b10, 64'd0, 1'b0, 6);
        chk("slow_aw_awvalid_cycles", 64'(aw_cyc), 64'd4);
        chk("slow_aw_wvalid_cycles", 64'(w_cyc), 64'd1);
        chk("slow_aw_bready_overlap", 64'(overlap), 64'd0);
        aw_wait = 0;

        // Misaligned LW
        do_req(1'b0, 64'h8000_0002, 64'd0, 2'b10, 64'd0, 1'b1, 1);
        chk("misalign_ar_cycles", 64'(ar_cyc), 64'd0);

        // Read with SLVERR
        slv_rresp = 2'b10; slv_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        do_req(1'b0, 64'h8000_0020, 64'd0, 2'b11, 64'd0, 1'b1, 3);
        slv_rresp = 2'b00;

        // Write with DECERR
        slv_bresp = 2'b11;
        exp_wdata = 64'h5566000000000000; exp_wstrb = 8'hC0;
        do_req(1'b1, 64'h8000_0036, 64'h5566, 2'b01, 64'd0, 1'b1, 3);
        slv_bresp = 2'b00;

        // Reset asserted while in RDATA
        r_hold = 1'b1;
        exp_addr = 64'h8000_0040; exp_size = 3'd3;
        u_if.valid = 1'b1; u_if.reqtyp = 1'b0; u_if.addr = 64'h8000_0040; u_if.size = 2'b11;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rready) begin seen = 1'b1; break; end
        end
        chk("rdata_state_reached", 64'(seen), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_handshakes", {61'd0, rready, arvalid, u_if.ready}, 64'd0);
        u_if.valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; r_hold = 1'b0;
        @(negedge clk);

        // Fresh read after reset release
        slv_rdata = 64'h0102030405060708;
        do_req(1'b0, 64'h8000_0048, 64'd0, 2'b11, 64'h0102030405060708, 1'b0, 3);

        // Silent slave, TIMEOUT = 8
        silent = 1'b1;
        do_req(1'b0, 64'h8000_0050, 64'd0, 2'b11, 64'd0, 1'b1, 9);
        chk("timeout_ar_cycles", 64'(ar_cyc), 64'd8);
        silent = 1'b0;

        // Byte read from the top lane
        slv_rdata = 64'h7700_0000_0000_0000;
        do_req(1'b0, 64'h8000_0007, 64'd0, 2'b00, 64'h77, 1'b0, 3);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
